loba_seq_div: RTL and testbench

- Sequential approximate unsigned divider, Q ≈ A / B; the inverse operation of the LOBA segmented multipliers.
- Detects the divisor's leading one and keeps only its top W bits (divisor truncation).
- Runs a restoring shift-subtract division of the full dividend by the truncated divisor, one quotient bit per cycle, then right-shifts the result back.
- Sits beside the LOBA multipliers in the approximate-arithmetic library, behind a valid/ready stream interface.

---
 rtl/loba_pkg.sv | 20 ++
 rtl/loba_lod.sv | 21 ++
 rtl/loba_seq_div.sv | 133 +++++++++++++
 tb/tb_loba_seq_div.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/loba_pkg.sv
// Shared types and width constants for the LOBA approximate-arithmetic blocks.
// Default widths match the reference divider configuration (N=16, W=4).
package loba_pkg;

  localparam int LOBA_N  = 16;
  localparam int LOBA_W  = 4;
  localparam int LOBA_SW = $clog2(LOBA_N);
  localparam int LOBA_RW = LOBA_W + 1;

  // Divide-by-zero quotient; wide enough to be truncated to any N up to 64.
  localparam logic [63:0] LOBA_DZ_ALL1 = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOD  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } loba_state_e;

endpackage

// File: rtl/loba_lod.sv
// Leading-one detector: index of the highest set bit, plus an all-zero flag.
// Purely combinational, no backpressure.
module loba_lod #(
  parameter int N  = 16,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  din_i,
  output logic [SW-1:0] idx_o,
  output logic          zero_o
);

  always_comb begin
    idx_o = '0;
    for (int k = 0; k < N; k++) begin
      if (din_i[k]) idx_o = k[SW-1:0];
    end
  end

  assign zero_o = ~|din_i;

endmodule

// File: rtl/loba_seq_div.sv
// Sequential LOBA approximate divider: Q ~= A / B with the divisor truncated to W bits below its leading one.
// Latency N+2 edges after acceptance (2 for B==0); one op in flight, result held until out_ready.
// Build option LOBA_DIV_ROUND_EN: round-to-nearest on the final right shift instead of truncating.
module loba_seq_div
  import loba_pkg::*;
#(
  parameter int N = LOBA_N,
  parameter int W = LOBA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Q,
  output logic         dz
);

  localparam int SW = $clog2(N);
  localparam int RW = W + 1;
  localparam logic [SW-1:0] WM1 = SW'(W - 1);

  loba_state_e   state_q;
  logic [N-1:0]  a_q, b_q, quo_q, q_q;
  logic [W-1:0]  bt_q;
  logic [SW-1:0] s_q, i_q;
  logic [RW-1:0] r_q;
  logic          zdiv_q, dz_q, out_valid_q, in_ready_q;

  logic [SW-1:0] lod_idx, s_d;
  logic          lod_zero;
  logic [W-1:0]  bt_d;
  logic [RW-1:0] r_sh_d, r_d;
  logic          qbit_d;
  logic [N-1:0]  q_trunc_d, q_d;

  loba_lod #(.N(N), .SW(SW)) u_lod (
    .din_i  (b_q),
    .idx_o  (lod_idx),
    .zero_o (lod_zero)
  );

  always_comb begin
    s_d    = (lod_idx >= WM1) ? lod_idx - WM1 : '0;
    bt_d   = W'(b_q >> s_d);
    // The stored remainder is always below Bt, so its top bit is never needed.
    r_sh_d = RW'({r_q, a_q[i_q]});
    qbit_d = (r_sh_d >= {1'b0, bt_q});
    r_d    = qbit_d ? r_sh_d - {1'b0, bt_q} : r_sh_d;
  end

`ifdef LOBA_DIV_ROUND_EN
  logic         rbit_d;
  logic [N:0]   q_sum_d;
  always_comb begin
    q_trunc_d = quo_q >> s_q;
    rbit_d    = (s_q != '0) ? quo_q[s_q - 1'b1] : 1'b0;
    q_sum_d   = {1'b0, q_trunc_d} + {{N{1'b0}}, rbit_d};
    q_d       = q_sum_d[N] ? {N{1'b1}} : q_sum_d[N-1:0];
  end
`else
  always_comb begin
    q_trunc_d = quo_q >> s_q;
    q_d       = q_trunc_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      quo_q       <= '0;
      q_q         <= '0;
      bt_q        <= '0;
      s_q         <= '0;
      i_q         <= '0;
      r_q         <= '0;
      zdiv_q      <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B;
            in_ready_q <= 1'b0;
            state_q    <= LOD;
          end
        end
        LOD: begin
          zdiv_q  <= lod_zero;
          s_q     <= lod_zero ? '0 : s_d;
          bt_q    <= bt_d;
          r_q     <= '0;
          quo_q   <= '0;
          i_q     <= SW'(N - 1);
          state_q <= lod_zero ? DONE : DIV;
        end
        DIV: begin
          r_q        <= r_d;
          quo_q[i_q] <= qbit_d;
          i_q        <= i_q - 1'b1;
          if (i_q == '0) state_q <= DONE;
        end
        DONE: begin
          // First DONE cycle registers the shifted result; then it is held for the consumer.
          if (!out_valid_q) begin
            q_q         <= zdiv_q ? N'(LOBA_DZ_ALL1) : q_d;
            dz_q        <= zdiv_q;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Q         = q_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_loba_seq_div.sv
// Self-checking bench for loba_seq_div (N=16, W=4): directed table, handshake/reset sequences, random sweep.
module tb_loba_seq_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_w = '0;
  logic [15:0] b_w = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] q_w;
  logic        dz_w;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  loba_seq_div dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a_w),
    .B         (b_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (q_w),
    .dz        (dz_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: truncate divisor to W bits under its leading one, exact divide, shift back.
  function automatic logic [16:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    int          kb, s;
    int unsigned bt, quo, q;
    if (b == 16'd0) return {1'b1, 16'hFFFF};
    kb = 0;
    for (int k = 0; k < 16; k++) if (b[k]) kb = k;
    s   = (kb > 3) ? kb - 3 : 0;
    bt  = int'(b) >> s;
    quo = int'(a) / bt;
    q   = quo >> s;
`ifdef LOBA_DIV_ROUND_EN
    if (s > 0) begin
      q = q + ((quo >> (s - 1)) & 1);
      if (q > 65535) q = 65535;
    end
`endif
    return {1'b0, q[15:0]};
  endfunction

  // One full transaction; 'hold' extra cycles with out_ready low after out_valid rises.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int hold,
                       output logic [15:0] q, output logic d, output int lat, output logic hs_ok);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    a_w = a; b_w = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    q = q_w; d = dz_w;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_q", q_w, q);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    hs_ok = !out_valid && in_ready;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        dz;
    int          lat;
  } vec_t;

  initial begin
    vec_t        vt[$];
    logic [15:0] q, ra, rb;
    logic        d, ok;
    logic [16:0] exp;
    int          lat, wdt;

    vt.push_back('{16'd1000,  16'd7,     16'd142,   1'b0, 18});
`ifdef LOBA_DIV_ROUND_EN
    vt.push_back('{16'd60000, 16'd1000,  16'd63,    1'b0, 18});
`else
    vt.push_back('{16'd60000, 16'd1000,  16'd62,    1'b0, 18});
`endif
    vt.push_back('{16'hFFFF,  16'd0,     16'hFFFF,  1'b1, 2});
    vt.push_back('{16'd10,    16'd3,     16'd3,     1'b0, 18});
    vt.push_back('{16'd5,     16'd9,     16'd0,     1'b0, 18});
    vt.push_back('{16'd100,   16'd10,    16'd10,    1'b0, 18});
    vt.push_back('{16'hFFFF,  16'd1,     16'hFFFF,  1'b0, 18});
    vt.push_back('{16'd0,     16'd5,     16'd0,     1'b0, 18});
    vt.push_back('{16'hFFFF,  16'hFFFF,  16'd1,     1'b0, 18});

    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q_w, 0);
    chk("rst_dz", dz_w, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (vt[k]) begin
      do_op(vt[k].a, vt[k].b, 0, q, d, lat, ok);
      chk($sformatf("vec%0d_q", k), q, vt[k].q);
      chk($sformatf("vec%0d_dz", k), d, vt[k].dz);
      chk($sformatf("vec%0d_lat", k), lat, vt[k].lat);
      chk($sformatf("vec%0d_handshake", k), ok, 1);
    end

    // Consumer stalls: result must stay frozen and inputs stay blocked.
    do_op(16'd5, 16'd9, 5, q, d, lat, ok);
    chk("stall_q", q, 0);
    chk("stall_release", ok, 1);

    // Reset while dividing drops the op; the next op must be clean.
    a_w = 16'd40000; b_w = 16'd300; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_idle_valid", out_valid, 0);
    do_op(16'd100, 16'd10, 0, q, d, lat, ok);
    chk("postrst_q", q, 10);
    chk("postrst_dz", d, 0);
    chk("postrst_lat", lat, 18);

    for (int r = 0; r < 3000; r++) begin
      ra  = 16'($urandom);
      wdt = $urandom_range(0, 16);
      rb  = 16'($urandom & ((32'd1 << wdt) - 1));
      exp = ref_div(ra, rb);
      do_op(ra, rb, 0, q, d, lat, ok);
      chk($sformatf("rand_%0d_%0d", ra, rb), {d, q}, {15'd0, exp});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
